// File: rtl/mul_iter.sv
// mul_iter: iterative shift-and-add multiplier returning the low NBITS of in0*in1
// over val/rdy streams; one partial product per cycle through a ripple-carry adder.
module mul_iter_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module mul_iter_rca #(
    parameter int NBITS = 32
) (
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    output logic [NBITS-1:0] sum
);
    logic [NBITS-1:0] c;
    assign c[0] = 1'b0;
    genvar i;
    generate
        for (i = 0; i < NBITS; i++) begin : g_bit
            if (i == NBITS - 1) begin : g_top
                // carry-out of the top bit is discarded (mod 2^NBITS)
                assign sum[i] = a[i] ^ b[i] ^ c[i];
            end else begin : g_fa
                mul_iter_fa u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(sum[i]), .co(c[i+1]));
            end
        end
    endgenerate
endmodule

module mul_iter #(
    parameter int NBITS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             istream_val,
    output logic             istream_rdy,
    input  logic [NBITS-1:0] in0,
    input  logic [NBITS-1:0] in1,
    output logic             ostream_val,
    input  logic             ostream_rdy,
    output logic [NBITS-1:0] out
);
    localparam int CW = (NBITS > 2) ? $clog2(NBITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NBITS - 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [NBITS-1:0] a_q, a_d, b_q, b_d, result_q, result_d, sum;
    logic [CW-1:0]    count_q, count_d;

    mul_iter_rca #(.NBITS(NBITS)) u_rca (.a(result_q), .b(a_q), .sum(sum));

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        count_d  = count_q;
        if (state_q == IDLE) begin
            if (istream_val) begin
                a_d      = in0;
                b_d      = in1;
                result_d = '0;
                count_d  = '0;
                state_d  = CALC;
            end
        end else if (state_q == CALC) begin
            result_d = b_q[0] ? sum : result_q;
            a_d      = a_q << 1;
            b_d      = b_q >> 1;
            count_d  = count_q + CW'(1);
            state_d  = (count_q == LAST) ? DONE : CALC;
        end else if (state_q == DONE) begin
            state_d = ostream_rdy ? IDLE : DONE;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            count_q  <= count_d;
        end
    end

    // state resets to IDLE, so rdy is masked by rst to stay low during reset
    assign istream_rdy = !rst && (state_q == IDLE);
    assign ostream_val = (state_q == DONE);
    assign out         = result_q;
endmodule

// File: tb/tb_mul_iter.sv
// tb_mul_iter: scoreboard bench for mul_iter; driver pushes expected products,
// an independent monitor pops and checks value, latency and handshake behaviour.
module tb_mul_iter;
    localparam int N = 32;

    typedef struct {
        logic [N-1:0] r;
        int           acc;
    } exp_t;

    logic         clk = 0, rst = 1, istream_val = 0, ostream_rdy = 1;
    logic [N-1:0] in0 = '0, in1 = '0;
    logic         istream_rdy, ostream_val;
    logic [N-1:0] out;
    exp_t         sb[$];
    int           total = 0, bad = 0, cyc = 0;
    bit           seen = 0, xfer = 0;

    mul_iter #(.NBITS(N)) dut (
        .clk(clk), .rst(rst), .istream_val(istream_val), .istream_rdy(istream_rdy),
        .in0(in0), .in1(in1), .ostream_val(ostream_val), .ostream_rdy(ostream_rdy), .out(out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            seen = 0;
            xfer = 0;
        end else begin
            if (xfer) begin
                chk("rdy_after_xfer", N'(istream_rdy), N'(1));
                chk("val_after_xfer", N'(ostream_val), N'(0));
                xfer = 0;
            end
            if (ostream_val) begin
                chk("rdy_in_done", N'(istream_rdy), N'(0));
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got %h want none", out);
                end else begin
                    if (!seen) chk("latency", N'(cyc - sb[0].acc), N'(N));
                    seen = 1;
                    chk("out", out, sb[0].r);
                    if (ostream_rdy) begin
                        void'(sb.pop_front());
                        seen = 0;
                        xfer = 1;
                    end
                end
            end
        end
    end

    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] p;
        @(posedge clk); #1;
        istream_val = 1;
        in0 = a;
        in1 = b;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (istream_rdy) begin
                p = a * b;
                sb.push_back('{r: p, acc: cyc + 1});
                @(posedge clk); #1;
                istream_val = 0;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL accept_timeout: got rdy=0 want rdy=1");
        istream_val = 0;
    endtask

    task automatic collect(input int bp);
        bit got = 0;
        @(posedge clk); #1;
        ostream_rdy = (bp == 0);
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = ostream_val;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL result_timeout: got val=0 want val=1");
            ostream_rdy = 1;
            return;
        end
        if (bp > 0) begin
            for (int j = 1; j < bp; j++) begin
                @(negedge clk);
                chk("bp_val_hold", N'(ostream_val), N'(1));
            end
            @(posedge clk); #1;
            ostream_rdy = 1;
            @(negedge clk);
        end
    endtask

    initial begin
        #1;
        chk("rst_irdy", N'(istream_rdy), N'(0));
        chk("rst_oval", N'(ostream_val), N'(0));
        chk("rst_out", out, N'(0));
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("rdy_after_rst", N'(istream_rdy), N'(1));

        issue(3, 4);                          collect(0);
        issue(32'hFFFFFFFF, 32'hFFFFFFFF);    collect(0);
        issue(32'hFFFFFFFD, 5);               collect(0);
        issue(32'h80000000, 2);               collect(0);
        issue(0, 32'h12345678);               collect(0);
        issue(7, 6);                          collect(5);

        issue(11, 13);
        repeat (5) @(posedge clk);
        #1;
        istream_val = 1;
        in0 = 9;
        in1 = 9;
        @(negedge clk);
        chk("busy_rdy", N'(istream_rdy), N'(0));
        issue(9, 9);                          collect(0);

        for (int k = 0; k < 10; k++) begin
            issue($urandom, $urandom);
            collect($urandom_range(0, 3));
        end

        issue(32'h1234, 32'h5678);
        repeat (10) @(posedge clk);
        #2;
        rst = 1;
        #1;
        chk("arst_oval", N'(ostream_val), N'(0));
        chk("arst_irdy", N'(istream_rdy), N'(0));
        chk("arst_out", out, N'(0));
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("rdy_after_arst", N'(istream_rdy), N'(1));
        issue(2, 3);                          collect(0);

        repeat (3) @(negedge clk);
        chk("sb_empty", N'(sb.size()), N'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
